// File: rtl/port_in_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | port_in_capture_if                                                   |
// | SFR access bus for the port input capture block: write strobe,      |
// | register select, write data and combinational read data.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface port_in_capture_if;
  logic       sfr_wr_i;
  logic [1:0] sfr_addr_i;
  logic [7:0] sfr_wdata_i;
  logic [7:0] sfr_rdata_o;

  // CPU side drives the access, reads back the selected register
  modport master (
    output sfr_wr_i,
    output sfr_addr_i,
    output sfr_wdata_i,
    input  sfr_rdata_o
  );

  // Peripheral side
  modport slave (
    input  sfr_wr_i,
    input  sfr_addr_i,
    input  sfr_wdata_i,
    output sfr_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/port_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | port_in_capture                                                      |
// | Per-bit pad synchronizer + debounce filter with edge-detect          |
// | interrupt flags (PXIE / PXEDG / PXIF / PXDBC SFRs).                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module port_in_capture #(
  parameter int DBW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ports_test_mode_i,
  input  logic [7:0]       y_port_i,
  input  logic [7:0]       en_port_i,
  port_in_capture_if.slave sfr,
  output logic [7:0]       pin_o,
  output logic             irq_o
);

  localparam logic [1:0]     c_addr_pxie  = 2'd0;
  localparam logic [1:0]     c_addr_pxedg = 2'd1;
  localparam logic [1:0]     c_addr_pxif  = 2'd2;
  localparam logic [1:0]     c_addr_pxdbc = 2'd3;
  localparam logic [DBW-1:0] c_dbc_rst    = DBW'(3);

  logic [7:0]     r_sync1;
  logic [7:0]     r_sync2;
  logic [7:0]     r_stable;
  logic [7:0]     r_pxie;
  logic [7:0]     r_pxedg;
  logic [7:0]     r_pxif;
  logic [DBW-1:0] r_dbc;
  logic           r_irq;

  logic [7:0]     w_stable_nxt;
  logic [7:0]     w_edge;
  logic [7:0]     w_clr;
  logic [7:0]     w_dbc_rd;
  logic           w_wr_ie;
  logic           w_wr_edg;
  logic           w_wr_if;
  logic           w_wr_dbc;

  assign w_wr_ie  = sfr.sfr_wr_i && (sfr.sfr_addr_i == c_addr_pxie);
  assign w_wr_edg = sfr.sfr_wr_i && (sfr.sfr_addr_i == c_addr_pxedg);
  assign w_wr_if  = sfr.sfr_wr_i && (sfr.sfr_addr_i == c_addr_pxif);
  assign w_wr_dbc = sfr.sfr_wr_i && (sfr.sfr_addr_i == c_addr_pxdbc);

  // Two-flop synchronizer; resets to all-ones to match idle pad level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= y_port_i;
      r_sync2 <= r_sync1;
    end
  end

  // One debounce counter per bit; the >= compare lets a lowered
  // threshold release a long-running count on the very next edge.
  generate
    for (genvar g = 0; g < 8; g++) begin : g_bit
      logic [DBW-1:0] r_cnt;
      logic [DBW-1:0] w_cnt_nxt;
      logic           w_nxt;

      // Next counter / stable value for this bit
      always_comb begin
        w_cnt_nxt = r_cnt;
        w_nxt     = r_stable[g];
        if (ports_test_mode_i) begin
          w_cnt_nxt = '0;
          w_nxt     = r_sync2[g];
        end else if (r_sync2[g] == r_stable[g]) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= r_dbc) begin
          w_cnt_nxt = '0;
          w_nxt     = r_sync2[g];
        end else begin
          w_cnt_nxt = r_cnt + DBW'(1);
        end
      end

      // Counter register; reset aborts any count in progress
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end

      assign w_stable_nxt[g] = w_nxt;
    end
  endgenerate

  // Edge events only on input-mode bits, polarity chosen by PXEDG
  assign w_edge = en_port_i & ((~r_stable &  w_stable_nxt &  r_pxedg) |
                               ( r_stable & ~w_stable_nxt & ~r_pxedg));

  assign w_clr = w_wr_if ? sfr.sfr_wdata_i : 8'h00;

  // Debounced value and SFR state; a new event wins over a same-cycle W1C
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stable <= 8'hFF;
      r_pxie   <= 8'h00;
      r_pxedg  <= 8'h00;
      r_pxif   <= 8'h00;
      r_dbc    <= c_dbc_rst;
      r_irq    <= 1'b0;
    end else begin
      r_stable <= w_stable_nxt;
      r_pxif   <= (r_pxif & ~w_clr) | w_edge;
      r_irq    <= |(r_pxif & r_pxie);
      if (w_wr_ie) begin
        r_pxie <= sfr.sfr_wdata_i;
      end
      if (w_wr_edg) begin
        r_pxedg <= sfr.sfr_wdata_i;
      end
      if (w_wr_dbc) begin
        r_dbc <= sfr.sfr_wdata_i[DBW-1:0];
      end
    end
  end

  // Zero-extend the debounce threshold for readback
  always_comb begin
    w_dbc_rd             = 8'h00;
    w_dbc_rd[DBW-1:0]    = r_dbc;
  end

  // Combinational read mux
  always_comb begin
    sfr.sfr_rdata_o = 8'h00;
    case (sfr.sfr_addr_i)
      c_addr_pxie:  sfr.sfr_rdata_o = r_pxie;
      c_addr_pxedg: sfr.sfr_rdata_o = r_pxedg;
      c_addr_pxif:  sfr.sfr_rdata_o = r_pxif;
      c_addr_pxdbc: sfr.sfr_rdata_o = w_dbc_rd;
      default:      sfr.sfr_rdata_o = 8'h00;
    endcase
  end

  assign pin_o = r_stable;
  assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_port_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_port_in_capture                                                   |
// | Directed self-checking bench for port_in_capture.                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_port_in_capture;

  logic       clk;
  logic       rst;
  logic       tm;
  logic [7:0] y;
  logic [7:0] en;
  logic [7:0] pin;
  logic       irq;
  int         checks;
  int         errors;

  port_in_capture_if bus ();

  port_in_capture #(.DBW(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ports_test_mode_i (tm),
    .y_port_i          (y),
    .en_port_i         (en),
    .sfr               (bus),
    .pin_o             (pin),
    .irq_o             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges, then settle past the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle SFR write; consumes exactly one edge
  task automatic sfr_write(input logic [1:0] a, input logic [7:0] d);
    bus.sfr_wr_i    = 1'b1;
    bus.sfr_addr_i  = a;
    bus.sfr_wdata_i = d;
    tick(1);
    bus.sfr_wr_i    = 1'b0;
  endtask

  task automatic sfr_read(input logic [1:0] a, output logic [7:0] d);
    bus.sfr_addr_i = a;
    #1;
    d = bus.sfr_rdata_o;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL reset_pin: got %h expected ff", pin); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    sfr_read(2'd0, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL reset_pxie: got %h expected 00", rd); end
    sfr_read(2'd1, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL reset_pxedg: got %h expected 00", rd); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL reset_pxif: got %h expected 00", rd); end
    sfr_read(2'd3, rd);
    checks++;
    if (rd !== 8'h03) begin errors++; $display("FAIL reset_pxdbc: got %h expected 03", rd); end
  endtask

  task automatic test_dbc0();
    logic [7:0] rd;
    sfr_write(2'd3, 8'hFF);
    sfr_read(2'd3, rd);
    checks++;
    if (rd !== 8'h0F) begin errors++; $display("FAIL pxdbc_upper: got %h expected 0f", rd); end
    sfr_write(2'd3, 8'h00);
    y = 8'hFE;
    tick(2);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL dbc0_pin_c2: got %h expected ff", pin); end
    tick(1);
    checks++;
    if (pin !== 8'hFE) begin errors++; $display("FAIL dbc0_pin_c3: got %h expected fe", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL dbc0_pxif: got %h expected 01", rd); end
    y = 8'hFF;
    tick(3);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL dbc0_return: got %h expected ff", pin); end
    sfr_write(2'd2, 8'h01);
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL dbc0_w1c: got %h expected 00", rd); end
  endtask

  task automatic test_debounce();
    logic [7:0] rd;
    sfr_write(2'd3, 8'h03);
    // 3-cycle glitch on bit2 must be filtered
    y = 8'hFB;
    tick(3);
    y = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (pin !== 8'hFF) begin errors++; $display("FAIL glitch_pin[%0d]: got %h expected ff", i, pin); end
    end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL glitch_pxif: got %h expected 00", rd); end
    // 4-cycle pulse passes: stable falls at edge 6, returns at edge 10
    y = 8'hFB;
    tick(4);
    y = 8'hFF;
    tick(1);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL pulse_pin_c5: got %h expected ff", pin); end
    tick(1);
    checks++;
    if (pin !== 8'hFB) begin errors++; $display("FAIL pulse_pin_c6: got %h expected fb", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h04) begin errors++; $display("FAIL pulse_pxif: got %h expected 04", rd); end
    tick(3);
    checks++;
    if (pin !== 8'hFB) begin errors++; $display("FAIL pulse_pin_c9: got %h expected fb", pin); end
    tick(1);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL pulse_pin_c10: got %h expected ff", pin); end
    sfr_write(2'd2, 8'hFF);
    // Threshold lowered below a running count releases on the next edge
    sfr_write(2'd3, 8'h0F);
    y = 8'hF7;
    tick(6);
    sfr_write(2'd3, 8'h02);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL lower_pin_c7: got %h expected ff", pin); end
    tick(1);
    checks++;
    if (pin !== 8'hF7) begin errors++; $display("FAIL lower_pin_c8: got %h expected f7", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h08) begin errors++; $display("FAIL lower_pxif: got %h expected 08", rd); end
    y = 8'hFF;
    tick(8);
    sfr_write(2'd2, 8'h08);
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL lower_clear: got %h expected 00", rd); end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    sfr_write(2'd3, 8'h00);
    sfr_write(2'd0, 8'h01);
    y = 8'hFE;
    tick(3);
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL irq_flag: got %h expected 01", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    sfr_write(2'd2, 8'h01);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", irq); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL irq_w1c: got %h expected 00", rd); end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    y = 8'hFF;
    tick(3);
    sfr_write(2'd0, 8'h00);
  endtask

  task automatic test_set_priority();
    logic [7:0] rd;
    sfr_write(2'd1, 8'h80);
    y = 8'h7F;
    tick(4);
    checks++;
    if (pin !== 8'h7F) begin errors++; $display("FAIL prio_fall_pin: got %h expected 7f", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL prio_fall_pxif: got %h expected 00", rd); end
    y = 8'hFF;
    tick(2);
    sfr_write(2'd2, 8'h80);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL prio_rise_pin: got %h expected ff", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h80) begin errors++; $display("FAIL prio_set_wins: got %h expected 80", rd); end
    sfr_write(2'd2, 8'h80);
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL prio_clear: got %h expected 00", rd); end
    sfr_write(2'd1, 8'h00);
  endtask

  task automatic test_en_masked();
    logic [7:0] rd;
    sfr_write(2'd0, 8'hFF);
    en = 8'h00;
    y  = 8'h00;
    tick(3);
    checks++;
    if (pin !== 8'h00) begin errors++; $display("FAIL mask_pin_lo: got %h expected 00", pin); end
    y = 8'hFF;
    tick(3);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL mask_pin_hi: got %h expected ff", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL mask_pxif: got %h expected 00", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b expected 0", irq); end
    // Flag already set survives the bit leaving input mode
    en = 8'hFF;
    y  = 8'hFE;
    tick(3);
    en = 8'h00;
    tick(2);
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL mask_keep_flag: got %h expected 01", rd); end
    sfr_write(2'd2, 8'hFF);
    sfr_write(2'd0, 8'h00);
    en = 8'hFF;
    y  = 8'hFF;
    tick(3);
  endtask

  task automatic test_test_mode();
    logic [7:0] rd;
    sfr_write(2'd3, 8'h0F);
    tm = 1'b1;
    y  = 8'hFD;
    tick(2);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL tm_pin_c2: got %h expected ff", pin); end
    tick(1);
    checks++;
    if (pin !== 8'hFD) begin errors++; $display("FAIL tm_pin_c3: got %h expected fd", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL tm_pxif: got %h expected 02", rd); end
    // Start a long count, then reset in the middle of it
    tm = 1'b0;
    y  = 8'hFF;
    tick(4);
    checks++;
    if (pin !== 8'hFD) begin errors++; $display("FAIL midcount_pin: got %h expected fd", pin); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL rst_mid_pin: got %h expected ff", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL rst_mid_pxif: got %h expected 00", rd); end
    sfr_read(2'd3, rd);
    checks++;
    if (rd !== 8'h03) begin errors++; $display("FAIL rst_mid_pxdbc: got %h expected 03", rd); end
    rst = 1'b0;
    tick(5);
    checks++;
    if (pin !== 8'hFF) begin errors++; $display("FAIL post_rst_pin: got %h expected ff", pin); end
    sfr_read(2'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL post_rst_pxif: got %h expected 00", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    tm              = 1'b0;
    y               = 8'hFF;
    en              = 8'hFF;
    bus.sfr_wr_i    = 1'b0;
    bus.sfr_addr_i  = 2'd0;
    bus.sfr_wdata_i = 8'h00;
    test_reset();
    test_dbc0();
    test_debounce();
    test_irq();
    test_set_priority();
    test_en_masked();
    test_test_mode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
